// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter for the PicoRV32 native memory bus.
// Round-robin or fixed-priority grant, grant held per transfer, bus-timeout watchdog.
module mem_bus_arbiter #(
  parameter int          PRIORITY_MODE  = 0,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter int          TMO_W          = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  input  logic        err_clr,
  output logic        dbg_state
);

  // Handshake: a master request is valid/ready; a transfer completes in the
  // cycle where the granted master's ready is high (from s_ready or timeout).

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             rr_last_q, rr_last_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_err_q, timeout_err_d;

  logic        busy, sel_m1, gnt_valid, tmo_hit, done_ok, done_tmo;
  logic        resp_ready;
  logic [31:0] resp_rdata;

  always_comb begin
    // Reset gates the datapath so an aborted transfer never sees a ready.
    busy       = (state_q == BUSY) && !reset;
    sel_m1     = grant_q[1];
    gnt_valid  = sel_m1 ? m1_valid : m0_valid;
    tmo_hit    = TMO_EN && (tmo_q == TMO_LIMIT);
    done_ok    = busy && gnt_valid && s_ready;
    done_tmo   = busy && gnt_valid && tmo_hit && !s_ready;
    resp_ready = done_ok || done_tmo;
    resp_rdata = done_tmo ? ERR_RDATA : s_rdata;

    s_valid  = busy && gnt_valid && !tmo_hit;
    s_instr  = busy && (sel_m1 ? m1_instr : m0_instr);
    s_addr   = busy ? (sel_m1 ? m1_addr  : m0_addr)  : 32'h0;
    s_wdata  = busy ? (sel_m1 ? m1_wdata : m0_wdata) : 32'h0;
    s_wstrb  = busy ? (sel_m1 ? m1_wstrb : m0_wstrb) : 4'h0;

    m0_ready = resp_ready && grant_q[0];
    m1_ready = resp_ready && grant_q[1];
    m0_rdata = (busy && grant_q[0]) ? resp_rdata : 32'h0;
    m1_rdata = (busy && grant_q[1]) ? resp_rdata : 32'h0;

    grant       = grant_q;
    timeout_err = timeout_err_q;
    dbg_state   = (state_q == BUSY);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_last_d     = rr_last_q;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;
    if (err_clr) timeout_err_d = 1'b0;
    if (done_tmo) timeout_err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = BUSY;
          tmo_d   = '0;
          // rr_last holds the index of the last master served.
          if (m0_valid && m1_valid)
            grant_d = ((PRIORITY_MODE == 1) || rr_last_q) ? 2'b01 : 2'b10;
          else
            grant_d = m1_valid ? 2'b10 : 2'b01;
        end
      end
      BUSY: begin
        if (resp_ready) begin
          state_d   = IDLE;
          grant_d   = 2'b00;
          rr_last_d = sel_m1;
        end else if (!gnt_valid) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end else if (!s_ready) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      rr_last_q     <= 1'b1;
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_last_q     <= rr_last_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a round-robin and a fixed-priority
// instance share one set of master/slave stimulus, both with an 8-cycle watchdog.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m0_instr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_wstrb = '0;
  logic        m1_valid = 1'b0, m1_instr = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wstrb = '0;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        err_clr = 1'b0;

  logic        rr_m0_ready, rr_m1_ready, rr_s_valid, rr_s_instr, rr_terr, rr_dbg;
  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
  logic [3:0]  rr_s_wstrb;
  logic [1:0]  rr_grant;
  logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_instr, fp_terr, fp_dbg;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_wstrb;
  logic [1:0]  fp_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(8), .TMO_W(16), .ERR_RDATA(32'hDEAD_BEEF)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(rr_m0_ready), .m0_rdata(rr_m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(rr_m1_ready), .m1_rdata(rr_m1_rdata),
    .s_valid(rr_s_valid), .s_instr(rr_s_instr), .s_addr(rr_s_addr), .s_wdata(rr_s_wdata),
    .s_wstrb(rr_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(rr_grant), .timeout_err(rr_terr), .err_clr(err_clr), .dbg_state(rr_dbg)
  );

  mem_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(8), .TMO_W(16), .ERR_RDATA(32'hDEAD_BEEF)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_instr(fp_s_instr), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_wstrb(fp_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(fp_grant), .timeout_err(fp_terr), .err_clr(err_clr), .dbg_state(fp_dbg)
  );

  // Inputs change 1 ns after the rising edge; checks run 3 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(); tick(); #3;
    chk("rst_grant", {30'h0, rr_grant}, 32'h0);
    chk("rst_s_valid", {31'h0, rr_s_valid}, 32'h0);
    chk("rst_ready", {30'h0, rr_m1_ready, rr_m0_ready}, 32'h0);
    chk("rst_terr", {31'h0, rr_terr}, 32'h0);
    chk("rst_state", {31'h0, rr_dbg}, 32'h0);

    // Single read by master 0, slave answers two cycles after s_valid.
    tick(); reset = 1'b0; m0_valid = 1'b1; m0_addr = 32'h0000_0040; #3;
    chk("t1_idle_grant", {30'h0, rr_grant}, 32'h0);
    chk("t1_idle_s_valid", {31'h0, rr_s_valid}, 32'h0);
    tick(); #3;
    chk("t1_grant", {30'h0, rr_grant}, 32'h1);
    chk("t1_s_valid", {31'h0, rr_s_valid}, 32'h1);
    chk("t1_s_addr", rr_s_addr, 32'h0000_0040);
    chk("t1_m0_ready_wait0", {31'h0, rr_m0_ready}, 32'h0);
    tick(); #3;
    chk("t1_m0_ready_wait1", {31'h0, rr_m0_ready}, 32'h0);
    tick(); s_ready = 1'b1; s_rdata = 32'h1234_5678; #3;
    chk("t1_m0_ready", {31'h0, rr_m0_ready}, 32'h1);
    chk("t1_m0_rdata", rr_m0_rdata, 32'h1234_5678);
    chk("t1_m1_ready", {31'h0, rr_m1_ready}, 32'h0);
    chk("t1_m1_rdata", rr_m1_rdata, 32'h0);
    tick(); m0_valid = 1'b0; s_ready = 1'b0; #3;
    chk("t1_back_idle", {30'h0, rr_grant}, 32'h0);
    chk("t1_ready_gone", {31'h0, rr_m0_ready}, 32'h0);

    // Contention with an always-ready slave; fresh reset so rr_last = 1.
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h0000_0040; m0_wdata = 32'h1111_2222; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h0000_0100; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF;
    s_ready = 1'b1; s_rdata = 32'h0000_0000; #3;
    chk("t2_idle", {30'h0, rr_grant}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick(); #3;
      chk("t2_rr_grant", {30'h0, rr_grant}, (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("t2_s_wdata", rr_s_wdata, (k % 2 == 0) ? 32'h1111_2222 : 32'hCAFE_F00D);
      chk("t2_s_wstrb", {28'h0, rr_s_wstrb}, (k % 2 == 0) ? 32'h0 : 32'hF);
      chk("t2_s_addr", rr_s_addr, (k % 2 == 0) ? 32'h40 : 32'h100);
      chk("t2_m0_ready", {31'h0, rr_m0_ready}, (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("t2_m1_ready", {31'h0, rr_m1_ready}, (k % 2 == 0) ? 32'h0 : 32'h1);
      chk("t3_fp_grant", {30'h0, fp_grant}, 32'h1);
      tick(); #3;
      chk("t2_gap_grant", {30'h0, rr_grant}, 32'h0);
      chk("t2_gap_s_valid", {31'h0, rr_s_valid}, 32'h0);
      chk("t3_fp_gap_grant", {30'h0, fp_grant}, 32'h0);
    end
    // Master 0 goes quiet while idle: only now may master 1 win under fixed priority.
    m0_valid = 1'b0;
    tick(); #3;
    chk("t3_fp_m1_grant", {30'h0, fp_grant}, 32'h2);
    chk("t3_fp_m1_ready", {31'h0, fp_m1_ready}, 32'h1);
    chk("t3_rr_m1_grant", {30'h0, rr_grant}, 32'h2);
    tick(); m1_valid = 1'b0; s_ready = 1'b0; #3;
    chk("t3_idle", {30'h0, fp_grant}, 32'h0);

    // Watchdog: slave never answers master 1.
    tick(); m1_valid = 1'b1; m1_addr = 32'h0000_0200; m1_wstrb = 4'h0; #3;
    tick(); #3;
    chk("t4_grant", {30'h0, rr_grant}, 32'h2);
    chk("t4_s_valid", {31'h0, rr_s_valid}, 32'h1);
    for (int i = 1; i < 8; i++) begin
      tick(); #3;
      chk("t4_wait_ready", {31'h0, rr_m1_ready}, 32'h0);
      chk("t4_wait_s_valid", {31'h0, rr_s_valid}, 32'h1);
    end
    tick(); #3;
    chk("t4_tmo_ready", {31'h0, rr_m1_ready}, 32'h1);
    chk("t4_tmo_rdata", rr_m1_rdata, 32'hDEAD_BEEF);
    chk("t4_tmo_s_valid", {31'h0, rr_s_valid}, 32'h0);
    chk("t4_tmo_m0_ready", {31'h0, rr_m0_ready}, 32'h0);
    chk("t4_terr_not_yet", {31'h0, rr_terr}, 32'h0);
    tick(); m1_valid = 1'b0; err_clr = 1'b1; #3;
    chk("t4_terr_set", {31'h0, rr_terr}, 32'h1);
    chk("t4_fp_terr_set", {31'h0, fp_terr}, 32'h1);
    chk("t4_idle", {30'h0, rr_grant}, 32'h0);
    tick(); err_clr = 1'b0; #3;
    chk("t4_terr_clr", {31'h0, rr_terr}, 32'h0);

    // Slave answers on the exact timeout cycle: slave data wins.
    tick(); m0_valid = 1'b1; m0_addr = 32'h0000_0080; m0_wstrb = 4'h0; #3;
    tick(); #3;
    chk("t5_grant", {30'h0, rr_grant}, 32'h1);
    for (int i = 1; i < 8; i++) begin
      tick(); #3;
      chk("t5_wait_ready", {31'h0, rr_m0_ready}, 32'h0);
    end
    tick(); s_ready = 1'b1; s_rdata = 32'h55AA_1234; #3;
    chk("t5_ready", {31'h0, rr_m0_ready}, 32'h1);
    chk("t5_rdata", rr_m0_rdata, 32'h55AA_1234);
    tick(); m0_valid = 1'b0; s_ready = 1'b0; #3;
    chk("t5_no_terr", {31'h0, rr_terr}, 32'h0);
    chk("t5_idle", {30'h0, rr_grant}, 32'h0);

    // Reset mid-transfer; master 0 was served last, so only a reset makes it win the tie.
    tick(); m1_valid = 1'b1; #3;
    tick(); #3;
    chk("t6_busy_grant", {30'h0, rr_grant}, 32'h2);
    reset = 1'b1; #1;
    chk("t6_rst_cycle_ready", {30'h0, rr_m1_ready, rr_m0_ready}, 32'h0);
    tick(); reset = 1'b0; m0_valid = 1'b1; #3;
    chk("t6_after_rst_grant", {30'h0, rr_grant}, 32'h0);
    chk("t6_after_rst_s_valid", {31'h0, rr_s_valid}, 32'h0);
    chk("t6_after_rst_ready", {30'h0, rr_m1_ready, rr_m0_ready}, 32'h0);
    tick(); s_ready = 1'b1; s_rdata = 32'h0BAD_F00D; #3;
    chk("t6_m0_wins_tie", {30'h0, rr_grant}, 32'h1);
    chk("t6_m0_ready", {31'h0, rr_m0_ready}, 32'h1);
    chk("t6_m0_rdata", rr_m0_rdata, 32'h0BAD_F00D);
    tick(); m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; #3;
    chk("t6_idle", {30'h0, rr_grant}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter on the native PicoRV32 memory interface (valid/ready, addr, wdata, wstrb, rdata).
- Shares the SoC memory/peripheral bus between the CPU (master 0) and a DMA/RX-copy engine (master 1), e.g. for moving SPI RX buffer contents into RAM without CPU load.
- Sits between the masters and the existing address decoder.
- Provides round-robin or fixed-priority grant, holds the grant across a transaction, and runs a bus-timeout watchdog that completes hung transfers with an error word.

Parameters:
- PRIORITY_MODE, 0: 0 = round-robin; 1 = fixed priority, master 0 always wins.
- TIMEOUT_CYCLES, 256: cycles a granted transfer may wait for s_ready. 0 disables the watchdog.
- TMO_W, 16: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^TMO_W.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned on a timed-out transfer.

Ports:
- clk, input, 1: single clock; all state on posedge.
- reset, input, 1: synchronous, active-high reset.
- m0_valid, input, 1: master 0 request.
- m0_instr, input, 1: master 0 instruction-fetch flag.
- m0_addr, input, 32: master 0 address.
- m0_wdata, input, 32: master 0 write data.
- m0_wstrb, input, 4: master 0 byte strobes (0 = read).
- m0_ready, output, 1: master 0 transfer complete.
- m0_rdata, output, 32: master 0 read data.
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as master 0, for master 1.
- s_valid, output, 1: request to slave/decoder.
- s_instr, output, 1: forwarded instr flag.
- s_addr, output, 32: forwarded address.
- s_wdata, output, 32: forwarded write data.
- s_wstrb, output, 4: forwarded strobes.
- s_ready, input, 1: slave completion.
- s_rdata, input, 32: slave read data.
- grant, output, 2: one-hot current owner (00 = idle).
- timeout_err, output, 1: sticky flag, set when any transfer times out.
- err_clr, input, 1: clears timeout_err.

Behaviour:
- States: IDLE, BUSY.
- Reset values: state = IDLE; grant = 00; s_valid = 0; m0_ready = m1_ready = 0; timeout_err = 0; rr_last = 1 (so master 0 wins the first tie); timeout counter = 0.
- Reset asserted mid-transfer aborts it: next cycle is IDLE, s_valid = 0, and no ready is issued to either master.
- IDLE:
  - Requests are sampled.
  - If any mN_valid = 1, register grant and enter BUSY on the next edge. Arbitration latency is 1 cycle.
  - s_valid = 0 in IDLE.
- Grant selection:
  - Single requester: that requester wins.
  - Both requesting, PRIORITY_MODE = 0: grant the master not equal to rr_last.
  - Both requesting, PRIORITY_MODE = 1: grant master 0.
  - rr_last updates to the granted master when a transfer completes normally or by timeout.
- BUSY:
  - s_valid, s_instr, s_addr, s_wdata and s_wstrb are combinationally muxed from the granted master; s_valid = granted mN_valid.
  - The granted master's mN_ready = s_ready and mN_rdata = s_rdata (combinational pass-through).
  - The non-granted master sees ready = 0 and rdata = 0.
- Completion:
  - The cycle with s_ready = 1 is the completion cycle.
  - Next edge: IDLE, grant = 00.
  - Back-to-back transfers therefore have a 1-cycle idle gap.
- Abort:
  - If the granted master drops valid in BUSY without s_ready, the arbiter returns to IDLE next edge.
  - No ready is issued and timeout_err is not set.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter clears on entry to BUSY and increments each BUSY cycle with s_ready = 0.
  - When counter == TIMEOUT_CYCLES, in that cycle: s_valid is forced to 0, granted mN_ready = 1, and mN_rdata = ERR_RDATA.
  - Next edge: IDLE and timeout_err set.
  - If s_ready and timeout coincide, the slave response wins and no error is flagged.
- timeout_err:
  - Cleared by err_clr on the next edge.
  - If a set and err_clr occur in the same cycle, the set wins.
- Invariants:
  - The non-granted master's request is held pending, never dropped.
  - At most one master ready per cycle.
  - s_valid is never asserted in IDLE.

Test Plan:
1. Single read: m0_valid, addr 0x0000_0040; slave returns 0x1234_5678 with s_ready 2 cycles after s_valid. Required: grant = 01 one cycle after m0_valid; m0_ready pulses one cycle with rdata 0x1234_5678; IDLE the following cycle.
2. Round-robin contention, PRIORITY_MODE = 0: m0 and m1 both hold valid for 4 transfers. Required: grant order m0, m1, m0, m1; one idle cycle between grants; m1 write (wstrb 4'hF, wdata 0xCAFE_F00D) reaches s_* unchanged.
3. Fixed priority, PRIORITY_MODE = 1: m0 issues continuous back-to-back requests while m1 is pending. Required: m1 is never granted until m0_valid is low in IDLE.
4. Timeout, TIMEOUT_CYCLES = 8: s_ready is held 0. Required: m1_ready = 1 with rdata 0xDEAD_BEEF exactly 8 BUSY cycles after grant; s_valid = 0 in that cycle; timeout_err = 1 next cycle. Then pulse err_clr → timeout_err = 0 next cycle.
5. Boundary coincidence: s_ready asserted on the exact timeout cycle → slave rdata is returned and timeout_err stays 0.
6. Reset mid-transfer: assert reset while in BUSY. Required: next cycle grant = 00, s_valid = 0, no mN_ready pulse. After release, a new m0 request is granted normally with rr_last = 1.
